chnl_rx_router: RTL

//   Controller that shares one Riffa RX channel among N_DEST downstream consumers.
//   It sequences the CHNL_RX/ACK/REN handshake, counts beats, and steers each

---
 rtl/chnl_rx_router_pkg.sv | 10 +
 rtl/chnl_rx_router_buf.sv | 24 ++
 rtl/chnl_rx_router.sv | 106 ++++++++++
 3 files changed

// File: rtl/chnl_rx_router_pkg.sv
// chnl_rx_router_pkg: router FSM states and an elaboration-time clog2 helper.
package chnl_rx_router_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/chnl_rx_router_buf.sv
// chnl_rx_router_buf: 1-entry registered stage, full throughput (accepts while popping).
module chnl_rx_router_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);
    assign in_rdy = !out_val || out_rdy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val  <= 1'b0;
            out_data <= '0;
        end else if (in_rdy) begin
            out_val <= in_val;
            if (in_val) out_data <= in_data;
        end
    end
endmodule

// File: rtl/chnl_rx_router.sv
// chnl_rx_router: shares one Riffa RX channel among N_DEST consumers,
// steering each transaction by CHNL_RX_OFF and draining unknown destinations.
module chnl_rx_router
    import chnl_rx_router_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int N_DEST           = 4,
    parameter int DEST_W           = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic [N_DEST-1:0]           o_val,
    input  logic [N_DEST-1:0]           o_rdy,
    output logic [C_PCI_DATA_WIDTH-1:0] o_data,
    output logic                        o_last,
    output logic                        busy,
    output logic [15:0]                 drop_cnt
);
    localparam int WPB = C_PCI_DATA_WIDTH / 32;
    localparam int SH  = clog2(WPB);
    localparam int BW  = C_PCI_DATA_WIDTH + 1 + DEST_W;

    state_t state, state_nx;
    logic [31:0] cnt, beats;
    logic [32:0] len_up;
    logic [DEST_W-1:0] dest, sel, stage_dest;
    logic [BW-1:0] stage_bus;
    logic [C_PCI_DATA_WIDTH-1:0] stage_data;
    logic stage_val, stage_last, in_rdy, out_rdy, accept, valid_dest;
    logic unused_dbg;

    assign CHNL_RX_CLK = clk;
    assign sel = CHNL_RX_OFF[DEST_W-1:0];
    // 33-bit round-up so LEN=0xFFFFFFFF cannot wrap to zero beats
    assign len_up = {1'b0, CHNL_RX_LEN} + 33'(WPB - 1);
    assign beats = 32'(len_up >> SH);
    assign valid_dest = 32'(sel) < N_DEST;
    assign CHNL_RX_ACK = state == S_RECV || state == S_DRAIN;
    assign CHNL_RX_DATA_REN = state == S_DRAIN || (state == S_RECV && in_rdy);
    assign accept = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
    assign busy = state != S_IDLE;
    assign unused_dbg = ^{CHNL_RX_LAST, CHNL_RX_OFF[30:DEST_W]};

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:         if (CHNL_RX) state_nx = beats == 32'd0 ? S_DONE : valid_dest ? S_RECV : S_DRAIN;
            S_RECV, S_DRAIN: if (accept && cnt == 32'd1) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dest     <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && CHNL_RX) begin
                cnt  <= beats;
                dest <= sel;
                if (!valid_dest && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else if (accept) begin
                cnt <= cnt - 32'd1;
            end
        end
    end

    // dest rides with each beat so the next transaction may enter behind a held last beat
    chnl_rx_router_buf #(.WIDTH(BW)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (CHNL_RX_DATA_VALID && state == S_RECV),
        .in_rdy   (in_rdy),
        .in_data  ({dest, cnt == 32'd1, CHNL_RX_DATA}),
        .out_val  (stage_val),
        .out_rdy  (out_rdy),
        .out_data (stage_bus)
    );

    assign {stage_dest, stage_last, stage_data} = stage_bus;
    assign o_data = stage_data;
    assign o_last = stage_val && stage_last;

    always_comb begin
        o_val   = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < N_DEST; i++) begin
            if (stage_dest == DEST_W'(i)) begin
                o_val[i] = stage_val;
                out_rdy  = o_rdy[i];
            end
        end
    end
endmodule
